// File: rtl/flexpipe_pkg.sv
// flexpipe_pkg: shared memory-request/response types and widths for the
// flexpipe memory subsystem, plus the per-channel state encoding used by
// the DRAM timing model.
//   mem_req_t  : addr, len (bytes), id, epoch, rtype, prio
//   mem_resp_t : data, id, epoch, last, error
package flexpipe_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned DATA_WIDTH   = 64;
    localparam int unsigned REQ_ID_WIDTH = 8;
    localparam int unsigned EPOCH_WIDTH  = 4;
    localparam int unsigned LEN_WIDTH    = 32;

    typedef enum logic [1:0] {
        RT_READ,
        RT_WRITE,
        RT_PREFETCH,
        RT_FLUSH
    } mem_rtype_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [LEN_WIDTH-1:0]    len;
        logic [REQ_ID_WIDTH-1:0] id;
        logic [EPOCH_WIDTH-1:0]  epoch;
        mem_rtype_e              rtype;
        logic [1:0]              prio;
    } mem_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   data;
        logic [REQ_ID_WIDTH-1:0] id;
        logic [EPOCH_WIDTH-1:0]  epoch;
        logic                    last;
        logic                    error;
    } mem_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } dram_ch_state_e;

    // Beats needed to return len bytes; widened to 33 bits so a len near
    // 2^32 cannot overflow the rounding add. A zero-length request still
    // produces one (error) beat.
    function automatic logic [32:0] beat_count(input logic [LEN_WIDTH-1:0] len,
                                               input int unsigned bw);
        if (len == '0) return 33'd1;
        return ({1'b0, len} + 33'(bw - 1)) / 33'(bw);
    endfunction

endpackage

// File: rtl/dram_req_fifo.sv
// dram_req_fifo: per-channel request queue for the DRAM model. Each request
// field lives in its own storage array; head entry is presented
// combinationally on o_rd_data.
//   i_wr_en/i_wr_data : enqueue (ignored when full)
//   i_rd_en           : dequeue head (ignored when empty)
//   o_full/o_empty/o_count : occupancy
module dram_req_fifo
    import flexpipe_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_en,
    input  mem_req_t               i_wr_data,
    input  logic                   i_rd_en,
    output mem_req_t               o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0]   r_addr  [DEPTH];
    logic [LEN_WIDTH-1:0]    r_len   [DEPTH];
    logic [REQ_ID_WIDTH-1:0] r_id    [DEPTH];
    logic [EPOCH_WIDTH-1:0]  r_epoch [DEPTH];
    mem_rtype_e              r_rtype [DEPTH];
    logic [1:0]              r_prio  [DEPTH];

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_wr_en && !o_full;
    assign w_pop   = i_rd_en && !o_empty;

    always_comb begin
        o_rd_data       = '0;
        o_rd_data.addr  = r_addr[r_rptr];
        o_rd_data.len   = r_len[r_rptr];
        o_rd_data.id    = r_id[r_rptr];
        o_rd_data.epoch = r_epoch[r_rptr];
        o_rd_data.rtype = r_rtype[r_rptr];
        o_rd_data.prio  = r_prio[r_rptr];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr]  <= i_wr_data.addr;
            r_len[r_wptr]   <= i_wr_data.len;
            r_id[r_wptr]    <= i_wr_data.id;
            r_epoch[r_wptr] <= i_wr_data.epoch;
            r_rtype[r_wptr] <= i_wr_data.rtype;
            r_prio[r_wptr]  <= i_wr_data.prio;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/dram_model_mc.sv
// dram_model_mc: multi-channel fixed-latency DRAM timing model.
//   mem_req/mem_req_valid/mem_req_ready : request in, routed to a channel by
//                                         addr[CH_SHIFT +: log2(NUM_CH)]
//   mem_resp/mem_resp_valid/mem_resp_ready : registered response beats
//   ch_busy : per channel, queue non-empty or channel not idle
// Each channel queues requests, waits FIXED_LATENCY cycles, then competes
// round-robin for the single response port and streams its beats.
module dram_model_mc
    import flexpipe_pkg::*;
#(
    parameter int unsigned NUM_CH             = 4,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned BW_BYTES_PER_CYCLE = DATA_WIDTH / 8,
    parameter int unsigned FIXED_LATENCY      = 120,
    parameter int unsigned CH_SHIFT           = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  mem_req_t          mem_req,
    input  logic              mem_req_valid,
    output logic              mem_req_ready,
    output mem_resp_t         mem_resp,
    output logic              mem_resp_valid,
    input  logic              mem_resp_ready,
    output logic [NUM_CH-1:0] ch_busy
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(FIXED_LATENCY + 1);

    logic [CH_W-1:0]   w_tgt;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_done;
    mem_req_t          w_ch_req [NUM_CH];
    logic              w_final_hs;

    logic [CH_W-1:0]   r_rr_ptr;
    logic [CH_W-1:0]   r_gnt_ch;
    logic [32:0]       r_beats_left;
    logic [ADDR_WIDTH-1:0] r_beat_addr;

    logic [CH_W-1:0]   w_gnt;
    logic [CH_W-1:0]   w_cand;
    logic              w_gnt_vld;
    logic [32:0]       w_gnt_beats;

    if (NUM_CH > 1) begin : g_sel
        assign w_tgt = mem_req.addr[CH_SHIFT +: CH_W];
    end else begin : g_sel_single
        assign w_tgt = '0;
    end

    // Back-pressure depends only on the addressed channel's queue.
    assign mem_req_ready = !w_full[w_tgt];
    assign w_final_hs    = mem_resp_valid && mem_resp_ready && mem_resp.last;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        dram_ch_state_e            r_state;
        dram_ch_state_e            w_state_nx;
        logic [CNT_W-1:0]          r_cnt;
        logic [CNT_W-1:0]          w_cnt_nx;
        mem_req_t                  r_req;
        mem_req_t                  w_head;
        logic                      w_wr;
        logic                      w_deq;
        logic [$clog2(FIFO_DEPTH):0] w_count;
        logic                      w_unused;

        assign w_wr = mem_req_valid && mem_req_ready && (w_tgt == CH_W'(c));

        dram_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr_en   (w_wr),
            .i_wr_data (mem_req),
            .i_rd_en   (w_deq),
            .o_rd_data (w_head),
            .o_full    (w_full[c]),
            .o_empty   (w_empty[c]),
            .o_count   (w_count)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_req   <= '0;
            end else begin
                r_state <= w_state_nx;
                r_cnt   <= w_cnt_nx;
                if (w_deq) r_req <= w_head;
            end
        end

        always_comb begin
            w_state_nx = r_state;
            w_cnt_nx   = r_cnt;
            w_deq      = 1'b0;
            case (r_state)
                IDLE: if (!w_empty[c]) begin
                    w_deq      = 1'b1;
                    w_cnt_nx   = CNT_W'(FIXED_LATENCY);
                    w_state_nx = WAIT;
                end
                WAIT: if (r_cnt <= CNT_W'(1)) w_state_nx = DONE;
                      else                    w_cnt_nx   = r_cnt - 1'b1;
                DONE: if (w_final_hs && (r_gnt_ch == CH_W'(c))) w_state_nx = IDLE;
                default: w_state_nx = IDLE;
            endcase
        end

        assign w_done[c]   = (r_state == DONE);
        assign w_ch_req[c] = r_req;
        assign ch_busy[c]  = !w_empty[c] || (r_state != IDLE);
        assign w_unused    = ^{w_count, r_req.rtype, r_req.prio};
    end

    // Scan from the round-robin pointer for the first channel in DONE.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            w_cand = CH_W'((32'(r_rr_ptr) + k) % NUM_CH);
            if (!w_gnt_vld && w_done[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = w_cand;
            end
        end
    end

    assign w_gnt_beats = beat_count(w_ch_req[w_gnt].len, BW_BYTES_PER_CYCLE);

    // A new stream is granted only while the output register is empty, so a
    // granted channel owns the port until its last beat handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_resp_valid <= 1'b0;
            mem_resp       <= '0;
            r_rr_ptr       <= '0;
            r_gnt_ch       <= '0;
            r_beats_left   <= '0;
            r_beat_addr    <= '0;
        end else if (mem_resp_valid) begin
            if (mem_resp_ready) begin
                if (mem_resp.last) begin
                    mem_resp_valid <= 1'b0;
                end else begin
                    mem_resp.data <= DATA_WIDTH'(r_beat_addr);
                    mem_resp.last <= (r_beats_left == 33'd1);
                    r_beats_left  <= r_beats_left - 33'd1;
                    r_beat_addr   <= r_beat_addr + ADDR_WIDTH'(BW_BYTES_PER_CYCLE);
                end
            end
        end else if (w_gnt_vld) begin
            mem_resp_valid <= 1'b1;
            mem_resp.data  <= DATA_WIDTH'(w_ch_req[w_gnt].addr);
            mem_resp.id    <= w_ch_req[w_gnt].id;
            mem_resp.epoch <= w_ch_req[w_gnt].epoch;
            mem_resp.last  <= (w_gnt_beats == 33'd1);
            mem_resp.error <= (w_ch_req[w_gnt].len == '0);
            r_beats_left   <= w_gnt_beats - 33'd1;
            r_beat_addr    <= w_ch_req[w_gnt].addr + ADDR_WIDTH'(BW_BYTES_PER_CYCLE);
            r_gnt_ch       <= w_gnt;
            r_rr_ptr       <= CH_W'((32'(w_gnt) + 1) % NUM_CH);
        end
    end

endmodule

// File: tb/tb_dram_model_mc.sv
// tb_dram_model_mc: directed bench for dram_model_mc (4 channels, depth 16,
// 8 bytes/beat, latency 10). Expected beats are queued per channel when a
// request is accepted and popped as beats handshake.
module tb_dram_model_mc;
    import flexpipe_pkg::*;

    localparam int unsigned NCH = 4;
    localparam int unsigned DEP = 16;
    localparam int unsigned BW  = 8;
    localparam int unsigned LAT = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    mem_req_t        mem_req;
    logic            mem_req_valid;
    logic            mem_req_ready;
    mem_resp_t       mem_resp;
    logic            mem_resp_valid;
    logic            mem_resp_ready;
    logic [NCH-1:0]  ch_busy;

    always #5 clk = ~clk;

    dram_model_mc #(
        .NUM_CH             (NCH),
        .FIFO_DEPTH         (DEP),
        .BW_BYTES_PER_CYCLE (BW),
        .FIXED_LATENCY      (LAT),
        .CH_SHIFT           (6)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req        (mem_req),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_resp       (mem_resp),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .ch_busy        (ch_busy)
    );

    typedef struct {
        logic [DATA_WIDTH-1:0] data;
        logic [7:0]            id;
        logic [3:0]            epoch;
        logic                  last;
        logic                  err;
        bit                    first;
    } exp_t;

    exp_t        sb [NCH][$];
    int unsigned exp_ch [256];
    int unsigned beats_seen [256];
    int unsigned gnt_log [$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc = 0;
    logic [7:0]  next_id = 8'd0;
    logic [7:0]  last_id = 8'd0;
    bit          prev_stall = 1'b0;
    mem_resp_t   prev_resp;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit sb_empty();
        for (int c = 0; c < NCH; c++) if (sb[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_exp(input mem_req_t r);
        int unsigned nb;
        int unsigned ch;
        logic [31:0] a;
        exp_t        e;
        nb = (r.len == 0) ? 1 : int'((64'(r.len) + 64'd7) / 64'd8);
        ch = int'(r.addr[7:6]);
        exp_ch[r.id]     = ch;
        beats_seen[r.id] = 0;
        a = r.addr;
        for (int unsigned k = 0; k < nb; k++) begin
            e.data  = {32'd0, a};
            e.id    = r.id;
            e.epoch = r.epoch;
            e.last  = (k == nb - 1);
            e.err   = (r.len == 0);
            e.first = (k == 0);
            sb[ch].push_back(e);
            a = a + 32'd8;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 of the following cycle.
    task automatic send(input logic [31:0] addr, input logic [31:0] len, output bit acc);
        mem_req_t r;
        r       = '0;
        r.addr  = addr;
        r.len   = len;
        r.id    = next_id;
        r.epoch = next_id[3:0] ^ 4'h5;
        r.rtype = RT_READ;
        r.prio  = 2'd1;
        mem_req       = r;
        mem_req_valid = 1'b1;
        @(negedge clk);
        acc = mem_req_ready;
        @(posedge clk);
        #1;
        mem_req_valid = 1'b0;
        if (acc) begin
            push_exp(r);
            acc_cyc = cyc;
            last_id = next_id;
            next_id++;
        end
    endtask

    task automatic drain(input int unsigned max_cyc);
        bit done;
        done = 1'b0;
        for (int unsigned i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk);
            done = sb_empty() && !mem_resp_valid;
        end
        chk("drain_complete", {95'd0, done}, 96'd1);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid_low", {95'd0, mem_resp_valid}, 96'd0);
        chk("rst_resp_zero", {18'd0, mem_resp}, 96'd0);
        chk("rst_busy_zero", {92'd0, ch_busy}, 96'd0);
        for (int c = 0; c < NCH; c++) sb[c].delete();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic quiet_window(input string tag, input int unsigned n);
        logic saw;
        saw = 1'b0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            saw = saw | mem_resp_valid;
        end
        chk(tag, {95'd0, saw}, 96'd0);
        step();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Beat monitor: holds-stable check while stalled, scoreboard on handshake.
    initial forever begin
        int unsigned ch;
        exp_t        e;
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold_stable", {17'd0, mem_resp_valid, mem_resp}, {17'd0, 1'b1, prev_resp});
            if (mem_resp_valid && mem_resp_ready) begin
                ch = exp_ch[mem_resp.id];
                if (sb[ch].size() == 0) begin
                    chk("spurious_beat", {95'd0, mem_resp_valid}, 96'd0);
                end else begin
                    e = sb[ch].pop_front();
                    chk("beat", {18'd0, mem_resp.data, mem_resp.id, mem_resp.epoch,
                                 mem_resp.last, mem_resp.error},
                                {18'd0, e.data, e.id, e.epoch, e.last, e.err});
                    if (e.first) gnt_log.push_back(ch);
                    beats_seen[mem_resp.id]++;
                end
            end
            prev_stall = mem_resp_valid && !mem_resp_ready;
            prev_resp  = mem_resp;
        end
    end

    initial begin
        bit          acc;
        bit          seen;
        int unsigned lat;
        int unsigned n_acc;
        logic [7:0]  id_a;
        logic [3:0]  pat;
        int unsigned exp_order [6];

        mem_req        = '0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b1;
        exp_order      = '{3, 0, 2, 1, 2, 0};

        // Reset state
        step(); step();
        chk("reset_valid", {95'd0, mem_resp_valid}, 96'd0);
        chk("reset_resp", {18'd0, mem_resp}, 96'd0);
        chk("reset_busy", {92'd0, ch_busy}, 96'd0);
        rst_n = 1'b1;
        step();
        chk("idle_ready", {95'd0, mem_req_ready}, 96'd1);

        // 32-byte read at 0x0: 4 beats, first beat LAT+2 cycles after accept
        send(32'h0, 32'd32, acc);
        chk("accept_ch0", {95'd0, acc}, 96'd1);
        chk("busy_after_accept", {92'd0, ch_busy}, 96'h1);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = mem_resp_valid;
        end
        lat = cyc - acc_cyc;
        chk("first_beat_latency", 96'(lat), 96'(LAT + 2));
        drain(200);
        chk("four_beats", 96'(beats_seen[last_id]), 96'd4);
        chk("busy_after_drain", {92'd0, ch_busy}, 96'd0);

        // Zero-length request on ch2: single error beat
        send(32'h80, 32'd0, acc);
        drain(200);
        chk("len0_beats", 96'(beats_seen[last_id]), 96'd1);

        // Address wrap and partial final beat on ch3
        send(32'hFFFF_FFF0, 32'd20, acc);
        drain(200);
        chk("wrap_beats", 96'(beats_seen[last_id]), 96'd3);

        // Consumer ready toggling 1,0,1,0 during a 4-beat burst
        send(32'h1C0, 32'd32, acc);
        id_a = last_id;
        pat  = 4'b1010;
        for (int i = 0; i < 80 && beats_seen[id_a] < 4; i++) begin
            mem_resp_ready = pat[3 - (i % 4)];
            step();
        end
        mem_resp_ready = 1'b1;
        chk("toggle_beats", 96'(beats_seen[id_a]), 96'd4);
        drain(200);

        // Round-robin: blocker on ch3, then ch0/ch2 contend; then blocker on ch1
        gnt_log.delete();
        send(32'hC0, 32'd160, acc);
        send(32'h00, 32'd32, acc);
        send(32'h80, 32'd32, acc);
        drain(400);
        send(32'h40, 32'd160, acc);
        send(32'h00, 32'd32, acc);
        send(32'h80, 32'd32, acc);
        drain(400);
        chk("rr_log_len", 96'(gnt_log.size()), 96'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk($sformatf("rr_order_%0d", i), 96'(gnt_log[i]), 96'(exp_order[i]));

        // Fill ch0 with the consumer stalled; one request sits in the channel
        // itself, so FIFO_DEPTH+1 are accepted before back-pressure.
        mem_resp_ready = 1'b0;
        n_acc = 0;
        acc = 1'b1;
        for (int i = 0; i < 24 && acc; i++) begin
            send(32'(i) * 32'h100, 32'd8, acc);
            if (acc) n_acc++;
        end
        chk("ch0_accepted", 96'(n_acc), 96'(DEP + 1));
        mem_req.addr = 32'h0;
        #1;
        chk("ch0_full_ready", {95'd0, mem_req_ready}, 96'd0);
        send(32'h40, 32'd8, acc);
        chk("ch1_accept_while_ch0_full", {95'd0, acc}, 96'd1);
        chk("busy_ch0_ch1", {92'd0, ch_busy}, 96'h3);
        mem_resp_ready = 1'b1;
        drain(1500);
        chk("busy_after_fill_drain", {92'd0, ch_busy}, 96'd0);

        // Reset while a request is waiting out its latency
        send(32'h40, 32'd32, acc);
        step(); step(); step(); step();
        do_reset();
        quiet_window("no_resp_after_wait_reset", 40);

        // Reset mid-burst
        send(32'h80, 32'd64, acc);
        id_a = last_id;
        for (int i = 0; i < 60 && beats_seen[id_a] < 2; i++) @(negedge clk);
        chk("burst_started", {95'd0, 1'(beats_seen[id_a] >= 2)}, 96'd1);
        step();
        do_reset();
        quiet_window("no_resp_after_burst_reset", 40);

        // Normal service after reset
        send(32'h0, 32'd16, acc);
        drain(200);
        chk("post_reset_beats", 96'(beats_seen[last_id]), 96'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
